pipe_stall_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage MiniMIPS32 pipeline.
- Merges stall requests from IF, ID, EXE and MEM into the per-register `stall` vector consumed by the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Sequences the multi-cycle divider hold in EXE.
- Generates the exception/ERET `flush` and redirect PC, and tracks orphaned AXI instruction fetches that must be discarded after a flush.

---
 rtl/pipe_stall_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central stall/flush controller for the five-stage MiniMIPS32
//               pipeline. Merges per-stage stall requests into the register
//               hold vector, sequences the multi-cycle divider hold in EXE,
//               produces the exception/ERET flush and redirect PC, and tracks
//               orphaned AXI instruction fetches that must be discarded
//               after a flush.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   cpu_clk_50M      in   1  clock
//   cpu_rst_n        in   1  asynchronous active-low reset
//   stallreq_if      in   1  IF waiting for inst_data_ok
//   stallreq_id      in   1  ID load-use hazard
//   stallreq_exe     in   1  EXE single-cycle hold (non-divider)
//   div_start        in   1  DIV/DIVU sitting in EXE
//   stallreq_mem     in   1  MEM waiting for the data bus
//   exc_valid        in   1  MEM-stage exception or ERET commit
//   exc_is_eret      in   1  qualifies exc_valid as ERET
//   cp0_epc          in  32  current EPC
//   inst_req_pending in   1  IF fetch issued, not yet returned
//   inst_data_ok     in   1  fetch data beat returns this cycle
//   stall            out  5  hold vector {MEM/WB,EXE/MEM,ID/EXE,IF/ID,PC}
//   flush            out  1  clear all pipeline registers at next edge
//   flush_pc         out 32  redirect PC, valid with flush
//   div_busy         out  1  divider sequencer not idle
//   div_done         out  1  quotient/remainder valid this cycle
//   fetch_discard    out  1  next inst_data_ok beat is from a flushed stream
//   stall_cycles     out 32  saturating count of stalled cycles
// ============================================================================
module pipe_stall_ctrl #(
    parameter int          DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_exe,
    input  logic        div_start,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        exc_is_eret,
    input  logic [31:0] cp0_epc,
    input  logic        inst_req_pending,
    input  logic        inst_data_ok,
    output logic [4:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        div_busy,
    output logic        div_done,
    output logic        fetch_discard,
    output logic [31:0] stall_cycles
);

    localparam logic [5:0] C_DIV_LAST = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef enum logic [0:0] {
        FD_IDLE    = 1'b0,
        FD_DISCARD = 1'b1
    } fd_state_t;

    div_state_t  div_state_q, div_state_d;
    logic [5:0]  div_cnt_q,   div_cnt_d;
    fd_state_t   fd_state_q,  fd_state_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        w_flush;
    logic        w_div_hold;

    // ------------------------------------------------------------------
    // Flush and redirect. Combinational outputs are also gated by reset
    // so every output reads 0 while reset is held, not just the registers.
    // ------------------------------------------------------------------
    assign w_flush = exc_valid & cpu_rst_n;
    assign flush   = w_flush;

    always_comb begin
        flush_pc = 32'h0;
        if (w_flush) begin
            flush_pc = exc_is_eret ? cp0_epc : EXC_VECTOR;
        end
    end

    // ------------------------------------------------------------------
    // Divider sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= 6'd0;
        end else begin
            div_state_q <= div_state_d;
            div_cnt_q   <= div_cnt_d;
        end
    end

    always_comb begin
        div_state_d = div_state_q;
        div_cnt_d   = div_cnt_q;
        // The start cycle itself is held so the DIV cannot slip out of EXE
        // before the sequencer has registered it.
        w_div_hold  = 1'b0;
        div_busy    = 1'b0;
        div_done    = 1'b0;
        case (div_state_q)
            DIV_IDLE: begin
                if (div_start && !w_flush) begin
                    w_div_hold  = 1'b1;
                    div_state_d = DIV_BUSY;
                    div_cnt_d   = C_DIV_LAST;
                end
            end
            DIV_BUSY: begin
                w_div_hold = 1'b1;
                div_busy   = 1'b1;
                if (w_flush) begin
                    div_state_d = DIV_IDLE;
                    div_cnt_d   = 6'd0;
                end else if (div_cnt_q == 6'd0) begin
                    div_state_d = DIV_DONE;
                end else begin
                    // A MEM stall does not freeze the count; the result simply
                    // waits in DIV_DONE.
                    div_cnt_d = div_cnt_q - 6'd1;
                end
            end
            DIV_DONE: begin
                div_busy = 1'b1;
                // A flush in this cycle kills the instruction, so its result
                // is never reported.
                div_done = !w_flush;
                if (w_flush || !stallreq_mem) begin
                    div_state_d = DIV_IDLE;
                end
            end
            default: begin
                div_state_d = DIV_IDLE;
                div_cnt_d   = 6'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch-discard tracker: one outstanding AXI beat at most, so a second
    // flush while already discarding still owes exactly one beat.
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            fd_state_q <= FD_IDLE;
        end else begin
            fd_state_q <= fd_state_d;
        end
    end

    always_comb begin
        fd_state_d = fd_state_q;
        case (fd_state_q)
            FD_IDLE: begin
                // A beat landing in the flush cycle is killed by the IF/ID
                // flush itself and needs no tracking.
                if (w_flush && inst_req_pending && !inst_data_ok) begin
                    fd_state_d = FD_DISCARD;
                end
            end
            FD_DISCARD: begin
                if (inst_data_ok) begin
                    fd_state_d = FD_IDLE;
                end
            end
            default: fd_state_d = FD_IDLE;
        endcase
    end

    assign fetch_discard = cpu_rst_n && (fd_state_q == FD_DISCARD);

    // ------------------------------------------------------------------
    // Hold vector. A prefix of ones stops the earlier registers while the
    // first zero above it bubbles the next register.
    // ------------------------------------------------------------------
    always_comb begin
        stall = 5'b00000;
        if (!cpu_rst_n || w_flush) begin
            stall = 5'b00000;
        end else if (stallreq_mem) begin
            stall = 5'b01111;
        end else if (w_div_hold || stallreq_exe) begin
            stall = 5'b00111;
        end else if (stallreq_id) begin
            stall = 5'b00011;
        end else if (stallreq_if || fetch_discard) begin
            stall = 5'b00001;
        end
    end

    // ------------------------------------------------------------------
    // Stall performance counter, saturating
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall != 5'b00000) && !w_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            stall_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed self-checking bench for pipe_stall_ctrl with a
//               four-cycle divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stallreq_if, stallreq_id, stallreq_exe, div_start, stallreq_mem;
    logic        exc_valid, exc_is_eret;
    logic [31:0] cp0_epc;
    logic        inst_req_pending, inst_data_ok;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        div_busy, div_done, fetch_discard;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    pipe_stall_ctrl #(
        .DIV_CYCLES(4),
        .EXC_VECTOR(32'hBFC00380)
    ) dut (
        .cpu_clk_50M      (clk),
        .cpu_rst_n        (rst_n),
        .stallreq_if      (stallreq_if),
        .stallreq_id      (stallreq_id),
        .stallreq_exe     (stallreq_exe),
        .div_start        (div_start),
        .stallreq_mem     (stallreq_mem),
        .exc_valid        (exc_valid),
        .exc_is_eret      (exc_is_eret),
        .cp0_epc          (cp0_epc),
        .inst_req_pending (inst_req_pending),
        .inst_data_ok     (inst_data_ok),
        .stall            (stall),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .div_busy         (div_busy),
        .div_done         (div_done),
        .fetch_discard    (fetch_discard),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen at the
    // falling edge in the middle of the cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if = 0; stallreq_id = 0; stallreq_exe = 0; div_start = 0;
        stallreq_mem = 0; exc_valid = 0; exc_is_eret = 0; cp0_epc = 32'h0;
        inst_req_pending = 0; inst_data_ok = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        stallreq_mem = 1; exc_valid = 1;
        @(negedge clk);
        total++;
        if (stall !== 5'b00000 || flush !== 1'b0 || flush_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: stall=%b flush=%b flush_pc=%h, need 00000 0 0", stall, flush, flush_pc);
        end
        total++;
        if (div_busy !== 0 || div_done !== 0 || fetch_discard !== 0 || stall_cycles !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b fd=%b sc=%0d, need all 0", div_busy, div_done, fetch_discard, stall_cycles);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (stall !== 5'b00000 || flush !== 1'b0 || stall_cycles !== 32'h0) begin
                bad++;
                $display("FAIL idle_after_reset: stall=%b flush=%b sc=%0d, need 00000 0 0", stall, flush, stall_cycles);
            end
            next_cycle();
        end
    endtask

    // stall_cycles leaves here at 4
    task automatic test_mem_id_stall();
        stallreq_mem = 1; stallreq_id = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (stall !== 5'b01111) begin
                bad++;
                $display("FAIL mem_id_stall: stall=%b need 01111", stall);
            end
            next_cycle();
        end
        stallreq_mem = 0;
        @(negedge clk);
        total++;
        if (stall !== 5'b00011 || stall_cycles !== 32'd3) begin
            bad++;
            $display("FAIL id_only_stall: stall=%b sc=%0d, need 00011 3", stall, stall_cycles);
        end
        next_cycle();
        stallreq_id = 0;
        @(negedge clk);
        total++;
        if (stall !== 5'b00000 || stall_cycles !== 32'd4) begin
            bad++;
            $display("FAIL stall_release: stall=%b sc=%0d, need 00000 4", stall, stall_cycles);
        end
        next_cycle();
    endtask

    // stall_cycles leaves here at 9
    task automatic test_div();
        div_start = 1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++;
            if (stall !== 5'b00111 || div_busy !== (i != 1) || div_done !== 1'b0) begin
                bad++;
                $display("FAIL div_hold_c%0d: stall=%b busy=%b done=%b, need 00111 %0d 0", i, stall, div_busy, div_done, (i != 1));
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (div_done !== 1'b1 || stall !== 5'b00000 || div_busy !== 1'b1) begin
            bad++;
            $display("FAIL div_done_c6: done=%b stall=%b busy=%b, need 1 00000 1", div_done, stall, div_busy);
        end
        next_cycle();
        div_start = 0;
        @(negedge clk);
        total++;
        if (div_busy !== 1'b0 || div_done !== 1'b0 || stall_cycles !== 32'd9) begin
            bad++;
            $display("FAIL div_idle_c7: busy=%b done=%b sc=%0d, need 0 0 9", div_busy, div_done, stall_cycles);
        end
        next_cycle();
    endtask

    // stall_cycles leaves here at 16
    task automatic test_div_mem_hold();
        div_start = 1;
        for (int i = 0; i < 5; i++) next_cycle();
        stallreq_mem = 1;
        for (int i = 6; i <= 7; i++) begin
            @(negedge clk);
            total++;
            if (div_done !== 1'b1 || stall !== 5'b01111) begin
                bad++;
                $display("FAIL div_mem_hold_c%0d: done=%b stall=%b, need 1 01111", i, div_done, stall);
            end
            next_cycle();
        end
        stallreq_mem = 0;
        @(negedge clk);
        total++;
        if (div_done !== 1'b1 || stall !== 5'b00000) begin
            bad++;
            $display("FAIL div_mem_release: done=%b stall=%b, need 1 00000", div_done, stall);
        end
        next_cycle();
        div_start = 0;
        @(negedge clk);
        total++;
        if (div_busy !== 1'b0 || div_done !== 1'b0 || stall_cycles !== 32'd16) begin
            bad++;
            $display("FAIL div_mem_idle: busy=%b done=%b sc=%0d, need 0 0 16", div_busy, div_done, stall_cycles);
        end
        next_cycle();
    endtask

    // stall_cycles leaves here at 17
    task automatic test_div_flush();
        div_start = 1;
        next_cycle();
        exc_valid = 1; exc_is_eret = 0; cp0_epc = 32'h12345678;
        @(negedge clk);
        total++;
        if (flush !== 1'b1 || flush_pc !== 32'hBFC00380 || stall !== 5'b00000) begin
            bad++;
            $display("FAIL exc_flush: flush=%b pc=%h stall=%b, need 1 bfc00380 00000", flush, flush_pc, stall);
        end
        next_cycle();
        exc_valid = 0; div_start = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (div_busy !== 1'b0 || div_done !== 1'b0 || flush !== 1'b0 || flush_pc !== 32'h0) begin
                bad++;
                $display("FAIL div_after_flush_%0d: busy=%b done=%b flush=%b pc=%h, need 0 0 0 0", i, div_busy, div_done, flush, flush_pc);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (stall_cycles !== 32'd17) begin
            bad++;
            $display("FAIL sc_after_div_flush: sc=%0d need 17", stall_cycles);
        end
        next_cycle();
    endtask

    // stall_cycles leaves here at 20
    task automatic test_eret_discard();
        exc_valid = 1; exc_is_eret = 1; cp0_epc = 32'h80001234;
        inst_req_pending = 1; inst_data_ok = 0;
        @(negedge clk);
        total++;
        if (flush !== 1'b1 || flush_pc !== 32'h80001234 || fetch_discard !== 1'b0) begin
            bad++;
            $display("FAIL eret_flush: flush=%b pc=%h fd=%b, need 1 80001234 0", flush, flush_pc, fetch_discard);
        end
        next_cycle();
        exc_valid = 0; exc_is_eret = 0;
        for (int i = 0; i < 3; i++) begin
            inst_data_ok = (i == 2);
            @(negedge clk);
            total++;
            if (fetch_discard !== 1'b1 || stall !== 5'b00001) begin
                bad++;
                $display("FAIL discard_c%0d: fd=%b stall=%b, need 1 00001", i, fetch_discard, stall);
            end
            next_cycle();
        end
        inst_data_ok = 0; inst_req_pending = 0;
        @(negedge clk);
        total++;
        if (fetch_discard !== 1'b0 || stall !== 5'b00000 || stall_cycles !== 32'd20) begin
            bad++;
            $display("FAIL discard_end: fd=%b stall=%b sc=%0d, need 0 00000 20", fetch_discard, stall, stall_cycles);
        end
        next_cycle();
    endtask

    // stall_cycles leaves here at 22
    task automatic test_flush_with_data_ok();
        exc_valid = 1; inst_req_pending = 1; inst_data_ok = 1;
        next_cycle();
        exc_valid = 0; inst_data_ok = 0; inst_req_pending = 0;
        @(negedge clk);
        total++;
        if (fetch_discard !== 1'b0) begin
            bad++;
            $display("FAIL flush_with_beat: fd=%b need 0", fetch_discard);
        end
        next_cycle();
        // Double flush: two flushes, one outstanding beat.
        exc_valid = 1; inst_req_pending = 1;
        next_cycle();
        exc_valid = 0;
        @(negedge clk);
        total++;
        if (fetch_discard !== 1'b1 || stall !== 5'b00001) begin
            bad++;
            $display("FAIL dbl_first: fd=%b stall=%b, need 1 00001", fetch_discard, stall);
        end
        next_cycle();
        exc_valid = 1;
        @(negedge clk);
        total++;
        if (fetch_discard !== 1'b1 || stall !== 5'b00000) begin
            bad++;
            $display("FAIL dbl_second_flush: fd=%b stall=%b, need 1 00000", fetch_discard, stall);
        end
        next_cycle();
        exc_valid = 0; inst_data_ok = 1;
        @(negedge clk);
        total++;
        if (fetch_discard !== 1'b1) begin
            bad++;
            $display("FAIL dbl_beat: fd=%b need 1", fetch_discard);
        end
        next_cycle();
        // A second beat after the discarded one is live fetch data.
        @(negedge clk);
        total++;
        if (fetch_discard !== 1'b0 || stall_cycles !== 32'd22) begin
            bad++;
            $display("FAIL dbl_one_beat: fd=%b sc=%0d, need 0 22", fetch_discard, stall_cycles);
        end
        next_cycle();
        inst_data_ok = 0; inst_req_pending = 0;
    endtask

    task automatic test_async_reset();
        div_start = 1; stallreq_exe = 1;
        exc_valid = 0; inst_req_pending = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (div_busy !== 1'b1 || stall_cycles !== 32'd24) begin
            bad++;
            $display("FAIL pre_reset: busy=%b sc=%0d, need 1 24", div_busy, stall_cycles);
        end
        #2;
        rst_n = 0;
        stallreq_mem = 1; exc_valid = 1;
        #1;
        total++;
        if (stall !== 5'b00000 || flush !== 1'b0 || flush_pc !== 32'h0 || div_busy !== 1'b0
            || div_done !== 1'b0 || fetch_discard !== 1'b0 || stall_cycles !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: stall=%b flush=%b pc=%h busy=%b done=%b fd=%b sc=%0d, need all 0",
                     stall, flush, flush_pc, div_busy, div_done, fetch_discard, stall_cycles);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1;
        @(negedge clk);
        total++;
        if (div_busy !== 1'b0 || stall !== 5'b00000 || stall_cycles !== 32'h0) begin
            bad++;
            $display("FAIL after_async_reset: busy=%b stall=%b sc=%0d, need 0 00000 0", div_busy, stall, stall_cycles);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_mem_id_stall();
        test_div();
        test_div_mem_hold();
        test_div_flush();
        test_eret_discard();
        test_flush_with_data_ok();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
